// File: rtl/fdiv_pkg.sv
// Shared types and helpers for the arbitrated floating-point divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: operand class enum, exponent/mantissa width helpers, exponent
// bias, canonical quiet-NaN constants and an operand classifier.
package fdiv_pkg;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

    function automatic int exp_w(input int n);
        return (n == 64) ? 11 : 8;
    endfunction

    function automatic int man_w(input int n);
        return (n == 64) ? 52 : 23;
    endfunction

    function automatic int bias(input int n);
        return (1 << (exp_w(n) - 1)) - 1;
    endfunction

    // Exponent and fraction arrive zero-extended to the double-precision
    // field widths so one function serves both formats. A zero exponent
    // (zero or subnormal) classifies as ZERO: subnormals are flushed.
    function automatic fp_class_t fp_classify(input logic [10:0] e,
                                              input logic [51:0] f,
                                              input logic [10:0] emax);
        fp_class_t c;
        if (e == 11'd0) begin
            c = ZERO;
        end else if (e == emax) begin
            c = (f == '0) ? INF : NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fdiv_arb_fmul.sv
// Combinational floating-point divide core for normal operands only.
// Latency: 0 (purely combinational).
// Backpressure: none.
//
// Ports: a (dividend), b (divisor), out (quotient, round-to-nearest-even,
// overflow to infinity, underflow flushed to signed zero).
module fmul
    import fdiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] out
);

    localparam int EW = exp_w(N);
    localparam int MW = man_w(N);
    localparam int QW = MW + 4;
    localparam int DW = 2 * MW + 4;
    localparam logic signed [EW+1:0] BIAS  = (EW + 2)'(bias(N));
    localparam logic signed [EW+1:0] EMAXS = (EW + 2)'((1 << EW) - 1);

    logic                   sign;
    logic [EW-1:0]          ea;
    logic [EW-1:0]          eb;
    logic [MW:0]            ma;
    logic [MW:0]            mb;
    logic [DW-1:0]          num;
    logic [DW-1:0]          den;
    logic [QW-1:0]          quo;
    logic [MW:0]            rem;
    logic                   hi;
    logic [MW:0]            mant;
    logic                   guard;
    logic                   sticky;
    logic                   rnd;
    logic [MW+1:0]          mant_r;
    logic signed [EW+1:0]   exp_q;
    logic [MW-1:0]          frac;

    always_comb begin
        sign = a[N-1] ^ b[N-1];
        ea   = a[N-2 -: EW];
        eb   = b[N-2 -: EW];
        ma   = {1'b1, a[MW-1:0]};
        mb   = {1'b1, b[MW-1:0]};

        // ma/mb lies in (0.5, 2); three extra quotient bits give a guard
        // bit plus sticky room in either normalisation case.
        num  = {ma, {(MW + 3){1'b0}}};
        den  = {{(MW + 3){1'b0}}, mb};
        quo  = QW'(num / den);
        rem  = (MW + 1)'(num % den);

        hi = quo[QW-1];
        if (hi) begin
            mant   = quo[QW-1:3];
            guard  = quo[2];
            sticky = |quo[1:0];
        end else begin
            mant   = quo[QW-2:2];
            guard  = quo[1];
            sticky = quo[0];
        end
        sticky = sticky | (|rem);
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + (MW + 2)'(rnd);

        exp_q = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        if (!hi) begin
            exp_q = exp_q - (EW + 2)'(1);
        end

        // Rounding carried out of the mantissa: renormalise.
        if (mant_r[MW+1]) begin
            exp_q = exp_q + (EW + 2)'(1);
            frac  = mant_r[MW:1];
        end else begin
            frac  = mant_r[MW-1:0];
        end

        if (exp_q >= EMAXS) begin
            out = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (exp_q <= 0) begin
            out = {sign, {(N - 1){1'b0}}};
        end else begin
            out = {sign, exp_q[EW-1:0], frac};
        end
    end

endmodule

// File: rtl/fdiv_arb_rr_arb.sv
// Round-robin arbiter: first set req at or after the pointer, wrapping.
// Latency: combinational grant; pointer updates on the granting edge.
// Backpressure: en=0 suppresses the grant and freezes the pointer.
//
// Ports: req (requests), en (grant allowed), gnt (one-hot), idx (winner).
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int TW = $clog2(NREQ);

    logic [TW-1:0] ptr_q;
    logic [TW-1:0] ptr_d;
    logic          found;
    int            j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = TW'(j);
            end
        end

        gnt = '0;
        if (en && found) begin
            gnt[idx] = 1'b1;
        end

        // Pointer moves just past the winner only when a grant is issued.
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (int'(idx) == NREQ - 1) ? '0 : TW'(idx + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fdiv_arb.sv
// Round-robin arbitrated FP divider: NREQ requesters share one divide core.
// Latency: accepted at edge k, result valid after edge k+1 (2 stages).
// Backpressure: valid/ready; res_ready=0 stalls S2, then S1, then req_ready.
//
// Ports: req_valid/req_ready/req_a/req_b (packed per requester, slot i at
// [i*N +: N]); res_valid/res_ready/res_q/res_tag/res_dz/res_nv (result).
module fdiv_arb
    import fdiv_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_q,
    output logic [$clog2(NREQ)-1:0] res_tag,
    output logic                    res_dz,
    output logic                    res_nv
);

    localparam int EW = exp_w(N);
    localparam int MW = man_w(N);
    localparam int TW = $clog2(NREQ);
    localparam logic [10:0]  EMAX = 11'((1 << EW) - 1);
    localparam logic [N-1:0] QNAN = (N == 64) ? N'(QNAN64) : N'(QNAN32);

    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s1_a_q, s1_a_d;
    logic [N-1:0]  s1_b_q, s1_b_d;
    logic [TW-1:0] s1_tag_q, s1_tag_d;

    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  s2_q_q, s2_q_d;
    logic [TW-1:0] s2_tag_q, s2_tag_d;
    logic          s2_dz_q, s2_dz_d;
    logic          s2_nv_q, s2_nv_d;

    logic            s1_ready;
    logic            s2_ready;
    logic            arb_en;
    logic [NREQ-1:0] arb_gnt;
    logic [TW-1:0]   arb_idx;
    logic            accept;

    logic [N-1:0]    core_q;
    fp_class_t       a_cls;
    fp_class_t       b_cls;
    logic            sign;
    logic [N-1:0]    sp_q;
    logic            sp_dz;
    logic            sp_nv;

    assign s2_ready = !s2_valid_q || res_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    // No grants while reset is held so nothing is accepted into a flushing pipe.
    assign arb_en   = s1_ready && !rst;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign req_ready = arb_gnt;
    assign accept    = |(req_valid & arb_gnt);

    fmul #(.N(N)) u_core (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .out (core_q)
    );

    // Special operands are resolved around the core; first match wins.
    always_comb begin
        a_cls = fp_classify(11'(s1_a_q[N-2 -: EW]), 52'(s1_a_q[MW-1:0]), EMAX);
        b_cls = fp_classify(11'(s1_b_q[N-2 -: EW]), 52'(s1_b_q[MW-1:0]), EMAX);
        sign  = s1_a_q[N-1] ^ s1_b_q[N-1];
        sp_q  = core_q;
        sp_dz = 1'b0;
        sp_nv = 1'b0;
        if (a_cls == NAN || b_cls == NAN ||
            (a_cls == ZERO && b_cls == ZERO) ||
            (a_cls == INF && b_cls == INF)) begin
            sp_q  = QNAN;
            sp_nv = 1'b1;
        end else if (a_cls == INF) begin
            sp_q = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (b_cls == ZERO) begin
            sp_q  = {sign, {EW{1'b1}}, {MW{1'b0}}};
            sp_dz = 1'b1;
        end else if (a_cls == ZERO || b_cls == INF) begin
            sp_q = {sign, {(N - 1){1'b0}}};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        // When S1 can move, it either takes a new pair or empties.
        if (s1_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d   = req_a[arb_idx*N +: N];
                s1_b_d   = req_b[arb_idx*N +: N];
                s1_tag_d = arb_idx;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_q_d     = s2_q_q;
        s2_tag_d   = s2_tag_q;
        s2_dz_d    = s2_dz_q;
        s2_nv_d    = s2_nv_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_q_d   = sp_q;
                s2_tag_d = s1_tag_q;
                s2_dz_d  = sp_dz;
                s2_nv_d  = sp_nv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_q_q     <= '0;
            s2_tag_q   <= '0;
            s2_dz_q    <= 1'b0;
            s2_nv_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_q_q     <= s2_q_d;
            s2_tag_q   <= s2_tag_d;
            s2_dz_q    <= s2_dz_d;
            s2_nv_q    <= s2_nv_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_q     = s2_q_q;
    assign res_tag   = s2_tag_q;
    assign res_dz    = s2_dz_q;
    assign res_nv    = s2_nv_q;

endmodule

// File: tb/tb_fdiv_arb.sv
// Directed bench for fdiv_arb: table of single divides, then hand-written
// round-robin, backpressure and mid-operation reset sequences.
module tb_fdiv_arb;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int TW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [N-1:0]         res_q;
    logic [TW-1:0]        res_tag;
    logic                 res_dz;
    logic                 res_nv;

    fdiv_arb #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_q     (res_q),
        .res_tag   (res_tag),
        .res_dz    (res_dz),
        .res_nv    (res_nv)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
        logic        nv;
    } vec_t;

    vec_t vecs [16];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One isolated divide: grant, one-cycle latency, then the result fields.
    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        req_a[v.tag*N +: N] = v.a;
        req_b[v.tag*N +: N] = v.b;
        req_valid           = '0;
        req_valid[v.tag]    = 1'b1;
        #1;
        check($sformatf("v%0d_grant", n), 64'(req_ready), 64'(1 << v.tag));
        @(posedge clk);
        #1;
        req_valid = '0;
        check($sformatf("v%0d_lat_early", n), 64'(res_valid), 64'(0));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_valid", n), 64'(res_valid), 64'(1));
        check($sformatf("v%0d_q", n), 64'(res_q), 64'(v.q));
        check($sformatf("v%0d_tag", n), 64'(res_tag), 64'(v.tag));
        check($sformatf("v%0d_dz", n), 64'(res_dz), 64'(v.dz));
        check($sformatf("v%0d_nv", n), 64'(res_nv), 64'(v.nv));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] acc;
        int              n_acc;
        int              got;
        logic [31:0]     exp_q [3];
        int              exp_t [3];

        vecs[0]  = '{1, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0}; // 6/2
        vecs[1]  = '{0, 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0}; // 1/-0
        vecs[2]  = '{2, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1}; // 0/0
        vecs[3]  = '{3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0}; // 1/3
        vecs[4]  = '{1, 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0}; // inf/2
        vecs[5]  = '{2, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0}; // -inf/2
        vecs[6]  = '{0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1}; // inf/-inf
        vecs[7]  = '{3, 32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0}; // -2/inf
        vecs[8]  = '{1, 32'h3F800000, 32'h7FC00001, 32'h7FC00000, 1'b0, 1'b1}; // 1/NaN
        vecs[9]  = '{0, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0}; // subn/1
        vecs[10] = '{2, 32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1, 1'b0}; // 1/subn
        vecs[11] = '{3, 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0}; // -6/2
        vecs[12] = '{1, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0}; // max/0.5
        vecs[13] = '{0, 32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 1'b0}; // 7/2
        vecs[14] = '{2, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0}; // 1/-1
        vecs[15] = '{3, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0}; // inf/0

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_q", 64'(res_q), 64'(0));
        check("rst_res_tag", 64'(res_tag), 64'(0));
        check("rst_res_dz", 64'(res_dz), 64'(0));
        check("rst_res_nv", 64'(res_nv), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Round-robin with every requester always asking.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = 32'h40C00000;
            req_b[i*N +: N] = 32'h40000000;
        end
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 5) begin
                check($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(1 << (c % NREQ)));
            end
            if (c >= 2) begin
                check($sformatf("rr_valid%0d", c), 64'(res_valid), 64'(1));
                check($sformatf("rr_tag%0d", c), 64'(res_tag), 64'((c - 2) % NREQ));
                check($sformatf("rr_q%0d", c), 64'(res_q), 64'(32'h40400000));
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: three pending requests, consumer stalled 5 cycles.
        do_reset();
        res_ready = 1'b0;
        req_a[0*N +: N] = 32'h40C00000; req_b[0*N +: N] = 32'h40000000;
        req_a[1*N +: N] = 32'h40E00000; req_b[1*N +: N] = 32'h40000000;
        req_a[2*N +: N] = 32'h3F800000; req_b[2*N +: N] = 32'h40400000;
        exp_q[0] = 32'h40400000; exp_t[0] = 0;
        exp_q[1] = 32'h40600000; exp_t[1] = 1;
        exp_q[2] = 32'h3EAAAAAB; exp_t[2] = 2;
        req_valid = 4'b0111;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc   = req_valid & req_ready;
            n_acc = n_acc + $countones(acc);
            if (c >= 2) begin
                check($sformatf("bp_hold_valid%0d", c), 64'(res_valid), 64'(1));
                check($sformatf("bp_hold_q%0d", c), 64'(res_q), 64'(exp_q[0]));
                check($sformatf("bp_hold_tag%0d", c), 64'(res_tag), 64'(exp_t[0]));
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        check("bp_accepts", 64'(n_acc), 64'(2));
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (res_valid) begin
                if (got < 3) begin
                    check($sformatf("bp_out_q%0d", got), 64'(res_q), 64'(exp_q[got]));
                    check($sformatf("bp_out_tag%0d", got), 64'(res_tag), 64'(exp_t[got]));
                end
                got++;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        check("bp_delivered", 64'(got), 64'(3));

        // Reset with both stages full; pointer is non-zero beforehand.
        res_ready = 1'b0;
        req_a[1*N +: N] = 32'h3F800000; req_b[1*N +: N] = 32'h00000000;
        req_a[2*N +: N] = 32'h00000000; req_b[2*N +: N] = 32'h00000000;
        req_valid = 4'b0110;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        check("mr_full_valid", 64'(res_valid), 64'(1));
        rst       = 1'b1;
        req_valid = '1;
        req_a[0*N +: N] = 32'h40C00000; req_b[0*N +: N] = 32'h40000000;
        @(posedge clk);
        #1;
        check("mr_res_valid", 64'(res_valid), 64'(0));
        check("mr_res_q", 64'(res_q), 64'(0));
        check("mr_req_ready", 64'(req_ready), 64'(0));
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("mr_ptr_zero_grant", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid) begin
                check($sformatf("mr_out_tag%0d", got), 64'(res_tag), 64'(0));
                check($sformatf("mr_out_q%0d", got), 64'(res_q), 64'(32'h40400000));
                got++;
            end
        end
        check("mr_result_count", 64'(got), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdiv_arb.md
# fdiv_arb

Shares one combinational floating-point divide core (`fmul`, ports `a`, `b`, `out`) among `NREQ` requesters. Each cycle the block picks one requester by round-robin and registers its operands. It then drives the core and registers the quotient with the requester's tag. A 2-stage valid/ready pipeline gives throughput of one divide per cycle, with full backpressure from the result consumer. Special operands are resolved here, not in the core.

## Interface
- `N`, 32: operand width; 32 or 64.
- `NREQ`, 4: number of requesters, 2..16.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  requester i has an operand pair.
- `req_ready`  out  NREQ  one-hot grant; the pair is accepted on a clock edge where `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ×N  dividends, packed; requester i is at `[i*N +: N]`.
- `req_b`  in  NREQ×N  divisors, packed the same way.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_q`  out  N  quotient.
- `res_tag`  out  clog2(NREQ)  index of the originating requester.
- `res_dz`  out  1  divide-by-zero flag (finite nonzero / ±0).
- `res_nv`  out  1  invalid flag; `res_q` is the canonical NaN.

## Operation
- **Stage S1** (`s1_valid`, `s1_a`, `s1_b`, `s1_tag`):
  - Loads when `s1_ready = !s1_valid | s2_ready` and some `req_valid` bit is set.
  - Otherwise `s1_valid` clears if S2 took its contents, and holds if not.
- **Stage S2** (`s2_valid`, `s2_q`, `s2_tag`, `s2_dz`, `s2_nv`):
  - Loads from S1 when `s2_ready = !s2_valid | res_ready`.
  - Outputs `res_*` come directly from S2.
- **Arbitration**:
  - Round-robin pointer `ptr` (clog2(NREQ) bits).
  - Winner is the first set `req_valid` bit at or after `ptr`, wrapping modulo NREQ.
  - `req_ready` is the winner one-hot, gated by `s1_ready`. It is zero when `s1_ready = 0`.
  - On acceptance, `ptr` becomes winner+1 mod NREQ; otherwise it holds.
  - `req_ready` must not depend on `req_a`/`req_b`.
- **Special-case resolution** (combinational on S1, first match wins):
  1. Either operand NaN, 0/0, or ∞/∞: `q` = canonical NaN (0x7FC00000 / 0x7FF8000000000000), `nv` = 1.
  2. `a` = ∞: `q` = ±∞.
  3. `b` = ±0 with `a` finite: `q` = ±∞, `dz` = 1.
  4. `a` = ±0 or `b` = ∞: `q` = ±0.
  5. Otherwise `q` = core output.
- **Sign**: the result sign is `a[N-1] ^ b[N-1]` in all non-NaN cases.
- **Subnormals**: subnormal inputs are treated as zero.

## Timing
- **Reset values**: `s1_valid` = 0, `s2_valid` = 0, `ptr` = 0, `req_ready` = 0. `res_valid` = 0, `res_q` = 0, `res_tag` = 0, `res_dz` = 0, `res_nv` = 0. Reset overrides any in-flight transfer, and in-flight data is discarded.
- **Latency**: a request accepted at edge k produces `res_valid` = 1 after edge k+1, when no stall occurs.
- **Throughput**: one acceptance per cycle while `res_ready` = 1.
- **Backpressure**:
  - `res_valid` and all `res_*` hold stable until `res_ready` = 1.
  - With S2 full and `res_ready` = 0, S1 still loads if it is empty. `req_ready` then drops to 0 the next cycle.
  - No result is lost or duplicated.
- **Simultaneous events**: S2 draining and S1 refilling on the same edge is legal. The pipeline stays full with no bubble.
- **Requester behaviour**: a requester that drops `req_valid` before being granted is never granted for that request.

## Structure
- **Package `fdiv_pkg`**:
  - Width functions `exp_w(N)` (8 / 11) and `man_w(N)` (23 / 52).
  - Bias, and canonical NaN constants per N.
  - Classification function returning a `fp_class_t` enum: ZERO, NORM, INF, NAN.
- **Sub-module `rr_arb`**: parameter NREQ, with inputs `req` and `en` and outputs `gnt` (one-hot) and `idx`. It holds the pointer and uses the same `clk`/`rst`.
- **Core**: one `fmul #(N)` instance between S1 and S2. It is purely combinational.

## Test plan
- **Normal divide**: reset, then requester 1 sends a=0x40C00000 (6.0), b=0x40000000 (2.0). Required response: `res_q` = 0x40400000, `res_tag` = 1, flags 0, `res_valid` 1 after edge k+1.
- **Divide by zero and invalid**:
  - a=0x3F800000, b=0x80000000 → `res_q` = 0xFF800000, `res_dz` = 1.
  - a=0, b=0 → `res_q` = 0x7FC00000, `res_nv` = 1.
- **Round-robin fairness**: all 4 `req_valid` held high with `res_ready` = 1. Required: grants in order 0,1,2,3,0 on consecutive cycles and tags in the same order.
- **Backpressure**: `res_ready` = 0 for 5 cycles with 3 requests pending. Required: `res_q`/`res_tag` stable, exactly 2 acceptances, then all 3 results delivered in order once `res_ready` = 1.
- **Reset mid-operation**: assert `rst` with S1 and S2 full. Required: `res_valid` = 0 and `ptr` = 0 next cycle, and no stale result appears afterward.
